dmem_lsu: RTL
=============

# dmem_lsu

Parametrised, byte-addressable data memory for the RISC-V core with RV32I load/store width handling (LB/LH/LW/LBU/LHU, SB/SH/SW). It replaces the plain word-only data memory: it adds a valid/ready request port, a registered one-cycle response, byte-lane writes, sign/zero extension, misalignment and range checking, and a hardware zero-fill sequence after reset. It sits between the core's execute/memory stage and on-chip RAM.

## Interface
- DEPTH, 64: memory size in 32-bit words; power of two, at least 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH*4.
- ERRCNT_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned; SB uses [7:0], SH uses [15:0].
- resp_valid  out  1  one-cycle pulse; response for the request accepted in the previous cycle.
- resp_err  out  1  qualified by resp_valid; request was illegal and had no effect.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- err_count  out  ERRCNT_W  number of erroneous requests, saturating.

## Operation
- States: INIT, IDLE. Reset forces INIT with init counter = 0.
- INIT: each cycle writes RAM[cnt] = 0 and increments cnt; after the write of cnt = DEPTH-1, the next state is IDLE. req_ready = 0.
- IDLE: req_ready = 1 every cycle. A request is accepted when req_valid && req_ready. Back-to-back acceptance every cycle; no backpressure on the response.
- Offset = req_addr - BASE_ADDR. The request is in range when 0 <= offset < DEPTH*4. Word index = offset[log2(DEPTH)+1:2]. Lane = offset[1:0].
- Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store funct3: 000 SB, 001 SH, 010 SW. All other encodings are errors.
- Misaligned: halfword with lane[0] = 1, or word with lane != 0. This is an error and the access is not split.
- Error (illegal funct3, misaligned, or out of range): no RAM write, resp_rdata = 0, resp_err = 1, err_count += 1 saturating at all-ones.
- Store: only the addressed byte lanes are written. SB writes lane L. SH writes lanes {2*lane[1], 2*lane[1]+1}. SW writes all four lanes. The write is committed on the accepting edge.
- Load: the word is read at the accepting edge. The selected byte or halfword is shifted to bit 0. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through. Little-endian lane order.
- Read-after-write: a load accepted in the cycle immediately after a store to the same word returns the updated bytes.

## Timing
- Reset values (the cycle after reset is sampled high): state INIT, cnt 0, req_ready 0, resp_valid 0, resp_err 0, resp_rdata 0, err_count 0.
- Zero-fill takes exactly DEPTH cycles. Counting the first cycle with reset low as cycle 0, req_ready is first 1 in cycle DEPTH.
- Latency: a request accepted in cycle N produces resp_valid = 1 with its resp_err and resp_rdata in cycle N+1 only. When nothing is accepted in cycle N, resp_valid = 0 in cycle N+1 and resp_rdata/resp_err return to 0.
- Reset mid-operation: a request presented in the same cycle as reset is not accepted, no write occurs, and no response follows. Any pending response is dropped, and zero-fill restarts from cnt 0.
- req_valid during INIT is ignored. No request is queued.

## Test plan
- Reset, then count cycles: req_ready = 0 for cycles 0..63 and 1 in cycle 64 (DEPTH = 64). LW from every word returns 0 with resp_err = 0.
- SW 0x8081_F00F @0x10, then LB/LBU/LH/LHU/LW @0x10..0x13: LB@0x13 = 0xFFFF_FF80, LBU@0x13 = 0x80, LH@0x12 = 0xFFFF_8081, LHU@0x10 = 0xF00F, LW = 0x8081_F00F.
- After SW 0 @0x20, issue SB 0xAA @0x21 then SH 0x1234 @0x22 back-to-back, then LW @0x20: returns 0x1234_AA00; each response arrives exactly one cycle after its request.
- Errors: LH @0x11, SW @0x06, funct3 = 011, LW @DEPTH*4, and SB with funct3 = 100. Each gives resp_err = 1 and resp_rdata = 0, the memory is unchanged (checked by LW), and err_count = 5.
- Assert reset while streaming stores: the store in the reset cycle is not written, resp_valid = 0 next cycle, and after the refill LW of previously written words returns 0.
- ERRCNT_W = 2, five erroneous requests: err_count is 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/dmem_lsu.sv
// Byte-addressable RV32I data memory with load/store width handling, a
// one-cycle registered response, error checking and a hardware zero-fill after reset.
module dmem_lsu #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERRCNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [31:0]         resp_rdata,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  typedef enum logic {INIT, IDLE} state_t;

  state_t         state;
  logic [AW-1:0]  cnt;
  logic           ready;
  logic [31:0]    mem [DEPTH];

  logic [31:0]    offset;
  logic [AW-1:0]  idx;
  logic [1:0]     lane;
  logic           legal;
  logic           misal;
  logic           err;
  logic           accept;
  logic           wr_en;
  logic [3:0]     be;
  logic [31:0]    wlanes;

  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [1:0]  ln,
                                           input logic [2:0]  f3);
    logic [31:0] sh;
    sh = word >> {ln, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'b0, sh[7:0]};
      3'b101:  return {16'b0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (&v) ? v : v + ERRCNT_W'(1);
  endfunction

  assign offset    = req_addr - BASE_ADDR;
  assign idx       = offset[AW+1:2];
  assign lane      = offset[1:0];
  assign req_ready = ready;

  // Width decode: byte-lane enables and store data replicated onto every lane
  always_comb begin
    legal  = 1'b0;
    misal  = 1'b0;
    be     = 4'b0000;
    wlanes = req_wdata;
    case (req_funct3)
      3'b000: begin
        legal  = 1'b1;
        be     = 4'b0001 << lane;
        wlanes = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        legal  = 1'b1;
        misal  = lane[0];
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        legal  = 1'b1;
        misal  = (lane != 2'b00);
        be     = 4'b1111;
      end
      3'b100: legal = !req_we;
      3'b101: begin
        legal  = !req_we;
        misal  = lane[0];
      end
      default: legal = 1'b0;
    endcase
  end

  assign err    = !legal || misal || (offset >= SPAN);
  assign accept = req_valid && ready;
  assign wr_en  = accept && req_we && !err;

  // RAM has no reset; zero-fill in INIT gives it a defined state
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[cnt] <= '0;
      end else if (wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      cnt        <= '0;
      ready      <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      err_count  <= '0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(DEPTH - 1)) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Response stage: registered one cycle after acceptance
      resp_valid <= accept;
      resp_err   <= accept && err;
      resp_rdata <= (accept && !err && !req_we) ? load_ext(mem[idx], lane, req_funct3) : '0;
      if (accept && err) err_count <= sat_inc(err_count);
    end
  end

endmodule
